logic_trigger_arbiter: RTL
==========================

LOGIC_TRIGGER_ARBITER -- requirements
Module: logic_trigger_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters sharing one logic engine/repeat unit.
REQ-002 SHALL have parameter RPTNO_W, default 16: repeat-count width.
REQ-003 SHALL have parameter RPTTIME_W, default 24: repeat-interval width.
REQ-004 SHALL have parameter WDOG_W, default 24: watchdog width.
REQ-005 SHALL have port io_clk, input, 1: single clock; all logic on the rising edge.
REQ-006 SHALL have port io_rst_n, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port io_req, input, NREQ: per-requester session request, level.
REQ-008 SHALL have port io_cfgRptNo, input, NREQ*RPTNO_W: per-requester repeat count, slice i.
REQ-009 SHALL have port io_cfgRptTime, input, NREQ*RPTTIME_W: per-requester repeat interval, slice i.
REQ-010 SHALL have port io_wdogCycles, input, WDOG_W: watchdog limit; 0 disables the watchdog.
REQ-011 SHALL have port io_abort, input, 1: abort the current session.
REQ-012 SHALL have port io_grant, output, NREQ: one-hot owner, held for the whole session.
REQ-013 SHALL have port io_done, output, NREQ: one-cycle completion pulse on the owner's bit.
REQ-014 SHALL have port io_status, output, 2: 00 ok, 01 timeout, 10 aborted; valid with io_done and held until the next io_done.
REQ-015 SHALL have port io_rptNo, output, RPTNO_W: to the repeat unit.
REQ-016 SHALL have port io_rptTime, output, RPTTIME_W: to the repeat unit.
REQ-017 SHALL have port io_mainTrigger, output, 1: one-cycle session-start pulse to the repeat unit.
REQ-018 SHALL have port io_logicStart, output, 1: one-cycle pass-start pulse to the logic engine.
REQ-019 SHALL have port io_logicEnd, input, 1: end-of-pass pulse from the logic engine.
REQ-020 SHALL have port io_rptEn, input, 1: repeat-interval-elapsed pulse from the repeat unit.

Function
REQ-021 SHALL implement the FSM IDLE, LOAD, START, RUN, WAIT_RPT, DONE.
REQ-022 IDLE SHALL drive io_rptNo=0 and io_rptTime=0 so the repeat unit's counters clear between sessions.
REQ-023 IDLE SHALL go to LOAD when any io_req bit is high, choosing the winner round-robin: highest priority is (last winner + 1) mod NREQ; after reset, requester 0 is highest.
REQ-024 In LOAD (cycle t+1 after request seen at t), io_grant SHALL assert and io_rptNo/io_rptTime SHALL take the winner's slices, held constant until IDLE; cfg changes mid-session SHALL be ignored.
REQ-025 START SHALL pulse io_mainTrigger and io_logicStart together for one cycle (t+2), clear passCnt and the watchdog, then go to RUN.
REQ-026 Required passes SHALL equal max(1, rptNo): rptNo of 0 or 1 means a single pass.
REQ-027 In RUN, on io_logicEnd passCnt SHALL increment; if passCnt+1 >= required passes go to DONE, else go to WAIT_RPT.
REQ-028 In WAIT_RPT, on io_rptEn io_logicStart SHALL pulse for one cycle and the FSM SHALL return to RUN; io_rptEn in any other state SHALL be ignored.
REQ-029 io_logicEnd outside RUN SHALL be ignored.
REQ-030 The watchdog SHALL count cycles in RUN and WAIT_RPT and clear on each accepted io_logicEnd or io_rptEn.
REQ-031 When io_wdogCycles != 0 and the watchdog count reaches io_wdogCycles, the FSM SHALL go to DONE with status 01.
REQ-032 io_abort high in LOAD, START, RUN or WAIT_RPT SHALL go to DONE with status 10.
REQ-033 Event priority SHALL be abort > timeout > logicEnd in the same cycle.
REQ-034 DONE SHALL pulse io_done[owner] for one cycle, set io_status (00 on normal completion), deassert io_grant, update the round-robin pointer, and return to IDLE.
REQ-035 Back-to-back sessions SHALL be separated by at least one IDLE cycle with io_rptNo=0.
REQ-036 Requests withdrawn before arbitration SHALL be dropped with no pulse.
REQ-037 A request held through its own io_done SHALL lose priority to any other pending requester.
REQ-038 io_grant SHALL be one-hot or zero in every cycle.

Reset
REQ-039 While io_rst_n=0, the FSM SHALL be IDLE and all outputs, passCnt, watchdog and status SHALL be 0; the round-robin pointer SHALL select requester 0.
REQ-040 Reset asserted mid-session SHALL immediately clear io_grant with no io_done pulse.

Verification
REQ-041 io_req=0001, rptNo=0 -> grant=0001 at t+1; mainTrigger and logicStart at t+2; one logicEnd -> done=0001, status 00.
REQ-042 io_req=0010, rptNo=3, rptTime=5 -> logicStart pulses 3 times, each later one the cycle after rptEn; done after the 3rd logicEnd.
REQ-043 io_req=1111 held continuously -> grants in order 0,1,2,3,0, with one session each.
REQ-044 wdogCycles=10 and no logicEnd -> done with status 01 exactly 10 cycles into RUN; wdogCycles=0 -> no timeout.
REQ-045 io_abort and logicEnd in the same RUN cycle -> status 10, no further logicStart.
REQ-046 io_rst_n low during WAIT_RPT -> all outputs 0 asynchronously; after release, requester 0 wins the next arbitration.

Source files
------------

// File: rtl/logic_trigger_arbiter.sv
// Round-robin arbiter that lends one logic engine and repeat unit to NREQ requesters,
// sequencing the trigger and repeat passes of each session with watchdog and abort handling.
module logic_trigger_arbiter #(
  parameter int NREQ      = 4,
  parameter int RPTNO_W   = 16,
  parameter int RPTTIME_W = 24,
  parameter int WDOG_W    = 24
) (
  input  logic                      io_clk,
  input  logic                      io_rst_n,
  input  logic [NREQ-1:0]           io_req,
  input  logic [NREQ*RPTNO_W-1:0]   io_cfgRptNo,
  input  logic [NREQ*RPTTIME_W-1:0] io_cfgRptTime,
  input  logic [WDOG_W-1:0]         io_wdogCycles,
  input  logic                      io_abort,
  output logic [NREQ-1:0]           io_grant,
  output logic [NREQ-1:0]           io_done,
  output logic [1:0]                io_status,
  output logic [RPTNO_W-1:0]        io_rptNo,
  output logic [RPTTIME_W-1:0]      io_rptTime,
  output logic                      io_mainTrigger,
  output logic                      io_logicStart,
  input  logic                      io_logicEnd,
  input  logic                      io_rptEn
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_RUN, S_WAIT_RPT, S_DONE
  } state_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_TIMEOUT = 2'b01,
    ST_ABORT   = 2'b10
  } status_e;

  state_e                 state_q, state_d;
  status_e                status_q, status_d, done_status;
  logic [NREQ-1:0]        grant_q, grant_d;
  logic [NREQ-1:0]        done_q, done_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [RPTNO_W-1:0]     rpt_no_q, rpt_no_d;
  logic [RPTTIME_W-1:0]   rpt_time_q, rpt_time_d;
  logic [RPTNO_W-1:0]     pass_cnt_q, pass_cnt_d;
  logic [WDOG_W-1:0]      wdog_q, wdog_d;
  logic                   main_trig_q, main_trig_d;
  logic                   logic_start_q, logic_start_d;

  logic                   win_vld;
  logic [IDX_W-1:0]       win_idx;
  logic [NREQ-1:0]        win_oh;
  logic [RPTNO_W-1:0]     win_rpt_no;
  logic [RPTTIME_W-1:0]   win_rpt_time;
  logic [IDX_W:0]         rr_sum;
  logic [IDX_W-1:0]       rr_cand;

  logic                   enter_done;
  logic                   timeout;
  logic [WDOG_W-1:0]      wdog_inc;
  logic [RPTNO_W:0]       pass_inc;
  logic [RPTNO_W:0]       passes_req;

  // Scan from the pointer upwards (wrapping) so the first live request found wins.
  // NOTE: every always_comb output gets a default before any branch; a path that
  // leaves one unassigned infers a latch.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    rr_sum  = '0;
    rr_cand = '0;
    for (int k = 0; k < NREQ; k++) begin
      rr_sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (rr_sum >= (IDX_W+1)'(NREQ)) rr_sum = rr_sum - (IDX_W+1)'(NREQ);
      rr_cand = rr_sum[IDX_W-1:0];
      if (!win_vld && io_req[rr_cand]) begin
        win_vld = 1'b1;
        win_idx = rr_cand;
      end
    end
  end

  always_comb begin
    win_oh       = '0;
    win_rpt_no   = '0;
    win_rpt_time = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        win_oh[i]    = 1'b1;
        win_rpt_no   = io_cfgRptNo[i*RPTNO_W +: RPTNO_W];
        win_rpt_time = io_cfgRptTime[i*RPTTIME_W +: RPTTIME_W];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    status_d      = status_q;
    grant_d       = grant_q;
    done_d        = '0;
    owner_d       = owner_q;
    rr_ptr_d      = rr_ptr_q;
    rpt_no_d      = rpt_no_q;
    rpt_time_d    = rpt_time_q;
    pass_cnt_d    = pass_cnt_q;
    wdog_d        = wdog_q;
    main_trig_d   = 1'b0;
    logic_start_d = 1'b0;
    enter_done    = 1'b0;
    done_status   = ST_OK;

    wdog_inc   = wdog_q + WDOG_W'(1);
    timeout    = (io_wdogCycles != '0) && (wdog_inc >= io_wdogCycles);
    pass_inc   = {1'b0, pass_cnt_q} + (RPTNO_W+1)'(1);
    passes_req = (rpt_no_q == '0) ? (RPTNO_W+1)'(1) : {1'b0, rpt_no_q};

    unique case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          state_d    = S_LOAD;
          grant_d    = win_oh;
          owner_d    = win_idx;
          rpt_no_d   = win_rpt_no;
          rpt_time_d = win_rpt_time;
        end
      end
      S_LOAD: begin
        if (io_abort) begin
          enter_done  = 1'b1;
          done_status = ST_ABORT;
        end else begin
          state_d       = S_START;
          main_trig_d   = 1'b1;
          logic_start_d = 1'b1;
        end
      end
      S_START: begin
        if (io_abort) begin
          enter_done  = 1'b1;
          done_status = ST_ABORT;
        end else begin
          state_d    = S_RUN;
          pass_cnt_d = '0;
          wdog_d     = '0;
        end
      end
      S_RUN: begin
        wdog_d = wdog_inc;
        if (io_abort) begin
          enter_done  = 1'b1;
          done_status = ST_ABORT;
        end else if (timeout) begin
          enter_done  = 1'b1;
          done_status = ST_TIMEOUT;
        end else if (io_logicEnd) begin
          pass_cnt_d = pass_inc[RPTNO_W-1:0];
          wdog_d     = '0;
          if (pass_inc >= passes_req) enter_done = 1'b1;
          else                        state_d    = S_WAIT_RPT;
        end
      end
      S_WAIT_RPT: begin
        wdog_d = wdog_inc;
        if (io_abort) begin
          enter_done  = 1'b1;
          done_status = ST_ABORT;
        end else if (timeout) begin
          enter_done  = 1'b1;
          done_status = ST_TIMEOUT;
        end else if (io_rptEn) begin
          state_d       = S_RUN;
          wdog_d        = '0;
          logic_start_d = 1'b1;
        end
      end
      S_DONE: begin
        // The finished owner drops to lowest priority for the next arbitration.
        state_d    = S_IDLE;
        rr_ptr_d   = (owner_q == IDX_W'(NREQ-1)) ? '0 : owner_q + IDX_W'(1);
        rpt_no_d   = '0;
        rpt_time_d = '0;
      end
      default: state_d = S_IDLE;
    endcase

    if (enter_done) begin
      state_d  = S_DONE;
      grant_d  = '0;
      done_d   = grant_q;
      status_d = done_status;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge io_clk or negedge io_rst_n) begin
    if (!io_rst_n) begin
      state_q       <= S_IDLE;
      status_q      <= ST_OK;
      grant_q       <= '0;
      done_q        <= '0;
      owner_q       <= '0;
      rr_ptr_q      <= '0;
      rpt_no_q      <= '0;
      rpt_time_q    <= '0;
      pass_cnt_q    <= '0;
      wdog_q        <= '0;
      main_trig_q   <= 1'b0;
      logic_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      status_q      <= status_d;
      grant_q       <= grant_d;
      done_q        <= done_d;
      owner_q       <= owner_d;
      rr_ptr_q      <= rr_ptr_d;
      rpt_no_q      <= rpt_no_d;
      rpt_time_q    <= rpt_time_d;
      pass_cnt_q    <= pass_cnt_d;
      wdog_q        <= wdog_d;
      main_trig_q   <= main_trig_d;
      logic_start_q <= logic_start_d;
    end
  end

  assign io_grant       = grant_q;
  assign io_done        = done_q;
  assign io_status      = status_q;
  assign io_rptNo       = rpt_no_q;
  assign io_rptTime     = rpt_time_q;
  assign io_mainTrigger = main_trig_q;
  assign io_logicStart  = logic_start_q;

endmodule
